// File: rtl/phv_deparser.sv
// phv_deparser
// Rebuilds the egress beat stream from processed PHVs. Each PHV and its action
// opcode are buffered in a small FIFO. For every PHV that is forwarded, one
// header beat (the PHV, zero-extended) is emitted, followed by that packet's
// payload beats passed straight through from the payload stream. A PHV whose
// action is DROP (8'h00) is discarded, and its payload is consumed silently.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   phv_valid/ready           PHV input handshake; ready while the FIFO is not full
//   phv_data, phv_action      processed PHV and its action opcode
//   pay_valid/ready           payload beat handshake
//   pay_data, pay_last        payload beat and its end-of-packet flag
//   pkt_valid/ready           egress beat handshake
//   pkt_data, pkt_sop/eop     egress beat with packet framing
//   pkt_count, drop_count     packets fully emitted / dropped (wrap at 2^32)
//   fifo_level                PHV FIFO occupancy, 0..FIFO_DEPTH
//
// state   | meaning
// IDLE    | waiting for a PHV; pops the FIFO head into hdr_reg
// HDR     | presenting the header beat until it is accepted
// PAYLOAD | passing payload beats through until the last one transfers
// DROP    | consuming payload beats of a dropped packet at full rate
module phv_deparser #(
    parameter int DATA_WIDTH     = 512,
    parameter int PHV_WIDTH      = 512,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      phv_valid,
    input  logic [PHV_WIDTH-1:0]      phv_data,
    input  logic [7:0]                phv_action,
    output logic                      phv_ready,
    input  logic                      pay_valid,
    input  logic [DATA_WIDTH-1:0]     pay_data,
    input  logic                      pay_last,
    output logic                      pay_ready,
    output logic                      pkt_valid,
    output logic [DATA_WIDTH-1:0]     pkt_data,
    output logic                      pkt_sop,
    output logic                      pkt_eop,
    input  logic                      pkt_ready,
    output logic [31:0]               pkt_count,
    output logic [31:0]               drop_count,
    output logic [FIFO_ADDR_BITS:0]   fifo_level
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [FIFO_ADDR_BITS:0] LEVEL_FULL = (FIFO_ADDR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [7:0]              ACT_DROP   = 8'h00;

    state_t                    state;
    state_t                    state_nxt;

    logic [PHV_WIDTH-1:0]      phv_mem [FIFO_DEPTH];
    logic [7:0]                act_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr;
    logic [PHV_WIDTH-1:0]      hdr_reg;
    logic [DATA_WIDTH-1:0]     hdr_ext;

    logic                      push;
    logic                      pop;
    logic                      cnt_pkt;
    logic                      cnt_drop;

    assign phv_ready = (fifo_level != LEVEL_FULL);
    assign push      = phv_valid && phv_ready;
    // A pop only happens from IDLE, so at most one PHV is in flight past the FIFO.
    assign pop       = (state == IDLE) && (fifo_level != '0);

    always_comb begin
        hdr_ext                = '0;
        hdr_ext[PHV_WIDTH-1:0] = hdr_reg;
    end

    // Storage has no reset: contents are only ever read behind fifo_level.
    always_ff @(posedge clk) begin
        if (push) begin
            phv_mem[wr_ptr] <= phv_data;
            act_mem[wr_ptr] <= phv_action;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            hdr_reg    <= '0;
            state      <= IDLE;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                hdr_reg <= phv_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (cnt_pkt) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (cnt_drop) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
        pay_ready = 1'b0;
        cnt_pkt   = 1'b0;
        cnt_drop  = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = (act_mem[rd_ptr] == ACT_DROP) ? DROP : HDR;
                end
            end
            HDR: begin
                pkt_valid = 1'b1;
                pkt_sop   = 1'b1;
                pkt_data  = hdr_ext;
                if (pkt_ready) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                pkt_valid = pay_valid;
                pkt_data  = pay_data;
                pkt_eop   = pay_last;
                pay_ready = pkt_ready;
                if (pay_valid && pkt_ready && pay_last) begin
                    cnt_pkt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                pay_ready = 1'b1;
                if (pay_valid && pay_last) begin
                    cnt_drop  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_phv_deparser.sv
// Self-checking bench for phv_deparser: directed scenarios plus randomized
// traffic scored against a packet-level model of the expected egress stream.
module tb_phv_deparser;

    localparam int DW = 512;
    localparam int PW = 512;
    localparam int AB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          phv_valid;
    logic [PW-1:0] phv_data;
    logic [7:0]    phv_action;
    logic          phv_ready;
    logic          pay_valid;
    logic [DW-1:0] pay_data;
    logic          pay_last;
    logic          pay_ready;
    logic          pkt_valid;
    logic [DW-1:0] pkt_data;
    logic          pkt_sop;
    logic          pkt_eop;
    logic          pkt_ready;
    logic [31:0]   pkt_count;
    logic [31:0]   drop_count;
    logic [AB:0]   fifo_level;

    phv_deparser #(
        .DATA_WIDTH     (DW),
        .PHV_WIDTH      (PW),
        .FIFO_DEPTH     (4),
        .FIFO_ADDR_BITS (AB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .phv_valid  (phv_valid),
        .phv_data   (phv_data),
        .phv_action (phv_action),
        .phv_ready  (phv_ready),
        .pay_valid  (pay_valid),
        .pay_data   (pay_data),
        .pay_last   (pay_last),
        .pay_ready  (pay_ready),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_sop    (pkt_sop),
        .pkt_eop    (pkt_eop),
        .pkt_ready  (pkt_ready),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Packet-level model: offered PHVs, offered payload beats, expected egress beats.
    logic [PW-1:0] q_phv[$];
    logic [7:0]    q_act[$];
    logic [DW-1:0] q_pay[$];
    bit            q_last[$];
    logic [DW-1:0] q_exp[$];
    bit            q_exp_sop[$];
    bit            q_exp_eop[$];
    int            phv_idx = 0;
    int            pay_idx = 0;
    int            exp_idx = 0;
    int            exp_pkt = 0;
    int            exp_drop = 0;

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic void add_packet(input logic [PW-1:0] phv, input logic [7:0] act, input int len);
        logic [DW-1:0] h;
        logic [DW-1:0] d;
        q_phv.push_back(phv);
        q_act.push_back(act);
        if (act != 8'h00) begin
            h = '0;
            h[PW-1:0] = phv;
            q_exp.push_back(h); q_exp_sop.push_back(1'b1); q_exp_eop.push_back(1'b0);
            exp_pkt++;
        end else begin
            exp_drop++;
        end
        for (int b = 0; b < len; b++) begin
            d = rand_wide();
            q_pay.push_back(d);
            q_last.push_back(b == len - 1);
            if (act != 8'h00) begin
                q_exp.push_back(d); q_exp_sop.push_back(1'b0); q_exp_eop.push_back(b == len - 1);
            end
        end
    endfunction

    function automatic void clear_model();
        q_phv.delete(); q_act.delete(); q_pay.delete(); q_last.delete();
        q_exp.delete(); q_exp_sop.delete(); q_exp_eop.delete();
        phv_idx = 0; pay_idx = 0; exp_idx = 0; exp_pkt = 0; exp_drop = 0;
    endfunction

    // Drives all queued traffic with random valid/ready gaps and scores every egress beat.
    task automatic run_traffic(input string name, input int ready_pct, input int phv_pct, input int pay_pct);
        int            cyc;
        bit            phv_acc;
        bit            pay_acc;
        bit            hold;
        logic [DW-1:0] held;
        cyc = 0; phv_acc = 1'b0; pay_acc = 1'b0; hold = 1'b0; held = '0;
        while (!(phv_idx == q_phv.size() && pay_idx == q_pay.size() && exp_idx == q_exp.size())
               && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (phv_acc || !phv_valid)
                phv_valid = (phv_idx < q_phv.size()) && ($urandom_range(99) < phv_pct);
            if (phv_valid) begin
                phv_data = q_phv[phv_idx]; phv_action = q_act[phv_idx];
            end
            if (pay_acc || !pay_valid)
                pay_valid = (pay_idx < q_pay.size()) && ($urandom_range(99) < pay_pct);
            if (pay_valid) begin
                pay_data = q_pay[pay_idx]; pay_last = q_last[pay_idx];
            end
            pkt_ready = ($urandom_range(99) < ready_pct);
            #1;
            phv_acc = phv_valid && phv_ready;
            if (phv_acc) phv_idx++;
            pay_acc = pay_valid && pay_ready;
            if (pay_acc) pay_idx++;
            if (hold) begin
                n_cmp++;
                if (pkt_valid !== 1'b1 || pkt_sop !== 1'b1 || pkt_data !== held) begin
                    n_err++;
                    $display("FAIL %s hdr_hold: valid=%b sop=%b data=%h, required valid=1 sop=1 data=%h",
                             name, pkt_valid, pkt_sop, pkt_data, held);
                end
            end
            if (pkt_valid === 1'b1 && pkt_sop === 1'b1) begin
                n_cmp++;
                if (pay_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s hdr_pay_stall: pay_ready=%b, required 0", name, pay_ready);
                end
            end
            hold = (pkt_valid === 1'b1) && (pkt_sop === 1'b1) && !pkt_ready;
            held = pkt_data;
            if (pkt_valid === 1'b1 && pkt_ready) begin
                n_cmp++;
                if (exp_idx >= q_exp.size()) begin
                    n_err++;
                    $display("FAIL %s extra_beat: got data=%h sop=%b eop=%b, required no beat",
                             name, pkt_data, pkt_sop, pkt_eop);
                end else begin
                    if (pkt_data !== q_exp[exp_idx] || pkt_sop !== q_exp_sop[exp_idx] ||
                        pkt_eop !== q_exp_eop[exp_idx]) begin
                        n_err++;
                        $display("FAIL %s beat%0d: got sop=%b eop=%b data=%h, required sop=%b eop=%b data=%h",
                                 name, exp_idx, pkt_sop, pkt_eop, pkt_data,
                                 q_exp_sop[exp_idx], q_exp_eop[exp_idx], q_exp[exp_idx]);
                    end
                    exp_idx++;
                end
            end
        end
        if (cyc >= 5000) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: beats seen %0d, required %0d", name, exp_idx, q_exp.size());
        end
        @(posedge clk);
        @(negedge clk);
        phv_valid = 1'b0; pay_valid = 1'b0; pkt_ready = 1'b0;
        #1;
        n_cmp++;
        if (pkt_count !== 32'(exp_pkt) || drop_count !== 32'(exp_drop)) begin
            n_err++;
            $display("FAIL %s counters: pkt=%0d drop=%0d, required pkt=%0d drop=%0d",
                     name, pkt_count, drop_count, exp_pkt, exp_drop);
        end
        n_cmp++;
        if (fifo_level !== '0 || pkt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_end: level=%0d valid=%b, required level=0 valid=0",
                     name, fifo_level, pkt_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; phv_valid = 1'b0; pay_valid = 1'b0; pkt_ready = 1'b0;
        phv_data = '0; phv_action = '0; pay_data = '0; pay_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (phv_ready !== 1'b1 || pay_ready !== 1'b0 || pkt_valid !== 1'b0 || pkt_sop !== 1'b0 ||
            pkt_eop !== 1'b0 || pkt_data !== '0 || fifo_level !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: phv_ready=%b pay_ready=%b valid=%b sop=%b eop=%b level=%0d, required 1 0 0 0 0 0",
                     phv_ready, pay_ready, pkt_valid, pkt_sop, pkt_eop, fifo_level);
        end
        n_cmp++;
        if (pkt_count !== 32'd0 || drop_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_counters: pkt=%0d drop=%0d, required 0 0", pkt_count, drop_count);
        end
    endtask

    task automatic test_single_forward();
        logic [PW-1:0] phv;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] hx;
        phv = rand_wide(); phv[7:0] = 8'hAB;
        d1 = rand_wide(); d2 = rand_wide();
        hx = '0; hx[PW-1:0] = phv;
        @(negedge clk);
        phv_valid = 1'b1; phv_data = phv; phv_action = 8'h01; pkt_ready = 1'b1;
        @(negedge clk);
        phv_valid = 1'b0;
        #1;
        n_cmp++;
        if (pkt_valid !== 1'b0 || fifo_level !== 3'd1) begin
            n_err++;
            $display("FAIL fwd_before_pop: valid=%b level=%0d, required valid=0 level=1", pkt_valid, fifo_level);
        end
        @(negedge clk);
        pay_valid = 1'b1; pay_data = d1; pay_last = 1'b0;
        #1;
        n_cmp++;
        if (pkt_valid !== 1'b1 || pkt_sop !== 1'b1 || pkt_eop !== 1'b0 || pkt_data !== hx || pay_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_header: valid=%b sop=%b eop=%b pay_ready=%b data=%h, required 1 1 0 0 data=%h",
                     pkt_valid, pkt_sop, pkt_eop, pay_ready, pkt_data, hx);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (pkt_valid !== 1'b1 || pkt_sop !== 1'b0 || pkt_eop !== 1'b0 || pkt_data !== d1 || pay_ready !== 1'b1) begin
            n_err++;
            $display("FAIL fwd_d1: valid=%b sop=%b eop=%b pay_ready=%b data=%h, required 1 0 0 1 data=%h",
                     pkt_valid, pkt_sop, pkt_eop, pay_ready, pkt_data, d1);
        end
        @(negedge clk);
        pay_data = d2; pay_last = 1'b1;
        #1;
        n_cmp++;
        if (pkt_valid !== 1'b1 || pkt_eop !== 1'b1 || pkt_data !== d2) begin
            n_err++;
            $display("FAIL fwd_d2: valid=%b eop=%b data=%h, required 1 1 data=%h", pkt_valid, pkt_eop, pkt_data, d2);
        end
        @(negedge clk);
        pay_valid = 1'b0; pay_last = 1'b0; pkt_ready = 1'b0;
        #1;
        exp_pkt++;
        n_cmp++;
        if (pkt_valid !== 1'b0 || pkt_count !== 32'(exp_pkt) || drop_count !== 32'(exp_drop)) begin
            n_err++;
            $display("FAIL fwd_done: valid=%b pkt=%0d drop=%0d, required 0 %0d %0d",
                     pkt_valid, pkt_count, drop_count, exp_pkt, exp_drop);
        end
    endtask

    task automatic test_drop();
        @(negedge clk);
        phv_valid = 1'b1; phv_data = rand_wide(); phv_action = 8'h00; pkt_ready = 1'b1;
        @(negedge clk);
        phv_valid = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            pay_valid = 1'b1; pay_data = rand_wide(); pay_last = (b == 2);
            #1;
            n_cmp++;
            if (pay_ready !== 1'b1 || pkt_valid !== 1'b0) begin
                n_err++;
                $display("FAIL drop_beat%0d: pay_ready=%b valid=%b, required 1 0", b, pay_ready, pkt_valid);
            end
            @(negedge clk);
        end
        pay_last = 1'b0;
        #1;
        exp_drop++;
        n_cmp++;
        if (drop_count !== 32'(exp_drop) || pkt_count !== 32'(exp_pkt) || pay_ready !== 1'b0 || pkt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drop_done: drop=%0d pkt=%0d pay_ready=%b valid=%b, required %0d %0d 0 0",
                     drop_count, pkt_count, pay_ready, pkt_valid, exp_drop, exp_pkt);
        end
        pay_valid = 1'b0; pkt_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int p = 0; p < 20; p++)
            add_packet(rand_wide(), ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                       $urandom_range(1, 4));
        run_traffic("backpressure", 35, 70, 70);
    endtask

    task automatic test_fifo_full();
        int lv[7];
        lv = '{1, 1, 2, 3, 4, 4, 4};
        for (int p = 0; p < 6; p++)
            add_packet(rand_wide(), 8'($urandom_range(1, 255)), $urandom_range(1, 2));
        pkt_ready = 1'b0; pay_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_cmp++;
                if (fifo_level !== 3'(lv[k-1])) begin
                    n_err++;
                    $display("FAIL full_level%0d: level=%0d, required %0d", k - 1, fifo_level, lv[k-1]);
                end
            end
            phv_valid = (phv_idx < q_phv.size());
            if (phv_valid) begin
                phv_data = q_phv[phv_idx]; phv_action = q_act[phv_idx];
            end
            #1;
            if (phv_valid && phv_ready) phv_idx++;
        end
        @(negedge clk);
        n_cmp++;
        if (fifo_level !== 3'(lv[6]) || phv_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_hold: level=%0d phv_ready=%b, required 4 0", fifo_level, phv_ready);
        end
        n_cmp++;
        if (phv_idx != q_phv.size() - 1) begin
            n_err++;
            $display("FAIL full_accepted: accepted=%0d, required %0d", phv_idx, q_phv.size() - 1);
        end
        run_traffic("fifo_full", 60, 80, 80);
    endtask

    task automatic test_mixed();
        logic [7:0] acts[4];
        acts = '{8'h01, 8'h00, 8'hFF, 8'h03};
        for (int p = 0; p < 4; p++) add_packet(rand_wide(), acts[p], $urandom_range(1, 3));
        run_traffic("mixed", 100, 100, 100);
    endtask

    task automatic test_reset_mid_payload();
        logic [DW-1:0] d1;
        d1 = rand_wide();
        @(negedge clk);
        phv_valid = 1'b1; phv_data = rand_wide(); phv_action = 8'h02; pkt_ready = 1'b1;
        @(negedge clk);
        phv_data = rand_wide(); phv_action = 8'h04;
        @(negedge clk);
        phv_valid = 1'b0;
        pay_valid = 1'b1; pay_data = d1; pay_last = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (pkt_valid !== 1'b1 || pkt_data !== d1) begin
            n_err++;
            $display("FAIL rstmid_d1: valid=%b data=%h, required 1 data=%h", pkt_valid, pkt_data, d1);
        end
        @(negedge clk);
        rst = 1'b1; pay_data = rand_wide();
        @(negedge clk);
        rst = 1'b0; pay_valid = 1'b0;
        #1;
        n_cmp++;
        if (pkt_valid !== 1'b0 || fifo_level !== '0 || pkt_count !== 32'd0 || drop_count !== 32'd0 || phv_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_state: valid=%b level=%0d pkt=%0d drop=%0d phv_ready=%b, required 0 0 0 0 1",
                     pkt_valid, fifo_level, pkt_count, drop_count, phv_ready);
        end
        pkt_ready = 1'b0;
        clear_model();
        add_packet(rand_wide(), 8'h05, 2);
        run_traffic("after_reset", 100, 100, 100);
    endtask

    initial begin
        test_reset();
        test_single_forward();
        test_drop();
        test_backpressure();
        test_fifo_full();
        test_mixed();
        test_reset_mid_payload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
